// File: rtl/mux_key_table.sv
// Runtime-writable key->value lookup table with a valid/ready request/response path,
// hit reporting, optional default value on miss and saturating hit/miss counters.
module mux_key_table #(
  parameter int KEY_NUM   = 4,
  parameter int KEY_WIDTH = 4,
  parameter int VAL_WIDTH = 8,
  parameter int HAS_DEF   = 1,
  parameter int CNT_WIDTH = 16,
  localparam int IDX_WIDTH = (KEY_NUM > 1) ? $clog2(KEY_NUM) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_en,
  input  logic [IDX_WIDTH-1:0] i_wr_idx,
  input  logic [KEY_WIDTH-1:0] i_wr_key,
  input  logic [VAL_WIDTH-1:0] i_wr_val,
  input  logic                 i_clr,
  input  logic [VAL_WIDTH-1:0] i_val_def,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [KEY_WIDTH-1:0] i_req_key,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [VAL_WIDTH-1:0] o_rsp_val,
  output logic                 o_rsp_hit,
  output logic [IDX_WIDTH-1:0] o_rsp_idx,
  output logic [CNT_WIDTH-1:0] o_hit_cnt,
  output logic [CNT_WIDTH-1:0] o_miss_cnt
);

  logic                 tbl_valid [KEY_NUM];
  logic [KEY_WIDTH-1:0] tbl_key   [KEY_NUM];
  logic [VAL_WIDTH-1:0] tbl_val   [KEY_NUM];

  logic                 rsp_valid;
  logic [VAL_WIDTH-1:0] rsp_val;
  logic                 rsp_hit;
  logic [IDX_WIDTH-1:0] rsp_idx;
  logic [CNT_WIDTH-1:0] hit_cnt;
  logic [CNT_WIDTH-1:0] miss_cnt;

  logic                 accept;
  logic                 match_hit;
  logic [IDX_WIDTH-1:0] match_idx;
  logic [VAL_WIDTH-1:0] match_val;
  logic [VAL_WIDTH-1:0] miss_val;

  assign o_req_ready = !rsp_valid || i_rsp_ready;
  assign accept      = i_req_valid && o_req_ready;
  assign miss_val    = (HAS_DEF != 0) ? i_val_def : '0;

  // Priority search: the first matching entry from index 0 upward wins.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    match_val = '0;
    for (int i = 0; i < KEY_NUM; i++) begin
      if (!match_hit && tbl_valid[i] && (tbl_key[i] == i_req_key)) begin
        match_hit = 1'b1;
        match_idx = IDX_WIDTH'(i);
        match_val = tbl_val[i];
      end
    end
  end

  // Write after clear so a same-cycle write survives; out-of-range indices match no entry.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < KEY_NUM; i++) begin
      if (i_rst) begin
        tbl_valid[i] <= 1'b0;
        tbl_key[i]   <= '0;
        tbl_val[i]   <= '0;
      end else begin
        if (i_clr) begin
          tbl_valid[i] <= 1'b0;
        end
        if (i_wr_en && (i_wr_idx == IDX_WIDTH'(i))) begin
          tbl_valid[i] <= 1'b1;
          tbl_key[i]   <= i_wr_key;
          tbl_val[i]   <= i_wr_val;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rsp_valid <= 1'b0;
      rsp_val   <= '0;
      rsp_hit   <= 1'b0;
      rsp_idx   <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_hit   <= match_hit;
      rsp_idx   <= match_hit ? match_idx : '0;
      rsp_val   <= match_hit ? match_val : miss_val;
    end else if (i_rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Statistics stick at all-ones rather than wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (accept) begin
      if (match_hit && (hit_cnt != '1)) begin
        hit_cnt <= hit_cnt + 1'b1;
      end
      if (!match_hit && (miss_cnt != '1)) begin
        miss_cnt <= miss_cnt + 1'b1;
      end
    end
  end

  assign o_rsp_valid = rsp_valid;
  assign o_rsp_val   = rsp_val;
  assign o_rsp_hit   = rsp_hit;
  assign o_rsp_idx   = rsp_idx;
  assign o_hit_cnt   = hit_cnt;
  assign o_miss_cnt  = miss_cnt;

endmodule

// File: tb/tb_mux_key_table.sv
// Scoreboard bench for mux_key_table: the driver pushes hand-computed responses on accept,
// a negedge monitor pops and compares each response the DUT presents.
module tb_mux_key_table;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_idx;
  logic [3:0] wr_key;
  logic [7:0] wr_val;
  logic       clr;
  logic [7:0] val_def;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_key;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_val;
  logic       rsp_hit;
  logic [1:0] rsp_idx;
  logic [1:0] hit_cnt;
  logic [1:0] miss_cnt;

  typedef struct packed {
    logic [7:0] val;
    logic       hit;
    logic [1:0] idx;
    logic [1:0] hc;
    logic [1:0] mc;
  } exp_t;

  exp_t       expq[$];
  exp_t       last;
  logic       seen;
  logic [1:0] exp_hc;
  logic [1:0] exp_mc;
  int         errors;
  int         checks;

  mux_key_table #(
    .KEY_NUM(4), .KEY_WIDTH(4), .VAL_WIDTH(8), .HAS_DEF(1), .CNT_WIDTH(2)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wr_en(wr_en), .i_wr_idx(wr_idx), .i_wr_key(wr_key), .i_wr_val(wr_val),
    .i_clr(clr), .i_val_def(val_def),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_key(req_key),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_val(rsp_val), .o_rsp_hit(rsp_hit), .o_rsp_idx(rsp_idx),
    .o_hit_cnt(hit_cnt), .o_miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_rsp_val"},   32'(rsp_val),   32'd0);
    checkOutput({tag, "_rsp_hit"},   32'(rsp_hit),   32'd0);
    checkOutput({tag, "_rsp_idx"},   32'(rsp_idx),   32'd0);
    checkOutput({tag, "_hit_cnt"},   32'(hit_cnt),   32'd0);
    checkOutput({tag, "_miss_cnt"},  32'(miss_cnt),  32'd0);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  // Issue one lookup; on acceptance push the expected response with the modelled counters.
  task automatic applyStimulus(input logic [3:0] key, input logic [7:0] val, input logic hit,
                               input logic [1:0] idx);
    exp_t e;
    bit   accepted = 1'b0;
    req_valid = 1'b1;
    req_key   = key;
    for (int c = 0; c < 20 && !accepted; c++) begin
      @(negedge clk);
      if (req_ready) accepted = 1'b1;
      @(posedge clk);
    end
    if (accepted) begin
      if (hit && exp_hc != 2'b11) exp_hc = exp_hc + 2'd1;
      if (!hit && exp_mc != 2'b11) exp_mc = exp_mc + 2'd1;
      e.val = val; e.hit = hit; e.idx = idx; e.hc = exp_hc; e.mc = exp_mc;
      expq.push_back(e);
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: key %0h never accepted, got 0 expected 1", key);
    end
    #1 req_valid = 1'b0;
  endtask

  task automatic writeEntry(input logic [1:0] idx, input logic [3:0] key, input logic [7:0] val);
    wr_en  = 1'b1;
    wr_idx = idx;
    wr_key = key;
    wr_val = val;
    @(posedge clk);
    #1 wr_en = 1'b0;
    clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: new responses are popped once; stalled responses must stay identical.
  always @(negedge clk) begin
    if (!rsp_valid) begin
      seen = 1'b0;
    end else begin
      if (!seen) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_rsp: got response val %0h expected none", rsp_val);
        end else begin
          last = expq.pop_front();
          seen = 1'b1;
          checkOutput("rsp_val",  32'(rsp_val),  32'(last.val));
          checkOutput("rsp_hit",  32'(rsp_hit),  32'(last.hit));
          checkOutput("rsp_idx",  32'(rsp_idx),  32'(last.idx));
          checkOutput("hit_cnt",  32'(hit_cnt),  32'(last.hc));
          checkOutput("miss_cnt", 32'(miss_cnt), 32'(last.mc));
        end
      end else begin
        checkOutput("hold_val", 32'(rsp_val), 32'(last.val));
        checkOutput("hold_hit", 32'(rsp_hit), 32'(last.hit));
        checkOutput("hold_idx", 32'(rsp_idx), 32'(last.idx));
      end
      if (rsp_ready) seen = 1'b0;
    end
  end

  initial begin
    errors = 0; checks = 0; seen = 1'b0;
    exp_hc = 2'd0; exp_mc = 2'd0;
    rst = 1'b1; wr_en = 1'b0; wr_idx = 2'd0; wr_key = 4'd0; wr_val = 8'd0; clr = 1'b0;
    val_def = 8'hEE; req_valid = 1'b0; req_key = 4'd0; rsp_ready = 1'b1;
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    checkResetState("reset");
    idle(1);

    $display("[TB] empty table miss, write/hit, lowest index wins");
    applyStimulus(4'h3, 8'hEE, 1'b0, 2'd0);
    writeEntry(2'd2, 4'h5, 8'hA5);
    applyStimulus(4'h5, 8'hA5, 1'b1, 2'd2);
    writeEntry(2'd1, 4'h7, 8'h11);
    writeEntry(2'd3, 4'h7, 8'h33);
    applyStimulus(4'h7, 8'h11, 1'b1, 2'd1);

    $display("[TB] same-cycle write is invisible to the lookup");
    wr_en = 1'b1; wr_idx = 2'd0; wr_key = 4'h9; wr_val = 8'h44;
    applyStimulus(4'h9, 8'hEE, 1'b0, 2'd0);
    wr_en = 1'b0;
    applyStimulus(4'h9, 8'h44, 1'b1, 2'd0);
    idle(1);

    $display("[TB] backpressure and back-to-back");
    rsp_ready = 1'b0;
    applyStimulus(4'h5, 8'hA5, 1'b1, 2'd2);
    fork
      applyStimulus(4'h7, 8'h11, 1'b1, 2'd1);
      begin
        repeat (3) begin
          @(negedge clk);
          checkOutput("stall_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
    join
    val_def = 8'h5A;
    applyStimulus(4'h3, 8'h5A, 1'b0, 2'd0);
    val_def = 8'hEE;
    idle(2);

    $display("[TB] counter saturation, clear, reset mid-response");
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    expq.delete();
    exp_hc = 2'd0; exp_mc = 2'd0;
    writeEntry(2'd2, 4'h5, 8'hA5);
    applyStimulus(4'h5, 8'hA5, 1'b1, 2'd2);
    for (int i = 0; i < 5; i++) applyStimulus(4'hC, 8'hEE, 1'b0, 2'd0);
    clr = 1'b1;
    writeEntry(2'd0, 4'h9, 8'h44);
    applyStimulus(4'h5, 8'hEE, 1'b0, 2'd0);
    applyStimulus(4'h9, 8'h44, 1'b1, 2'd0);
    idle(1);
    rsp_ready = 1'b0;
    applyStimulus(4'h9, 8'h44, 1'b1, 2'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    rsp_ready = 1'b1;
    expq.delete();
    exp_hc = 2'd0; exp_mc = 2'd0;
    @(negedge clk);
    checkResetState("midrst");
    idle(1);
    applyStimulus(4'h9, 8'hEE, 1'b0, 2'd0);
    idle(3);

    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending responses expected 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
